alarm_trigger: RTL
==================

# alarm_trigger

Alarm trigger and ringer stage placed directly downstream of the alarm-time setter. It compares the running clock time against the stored alarm hour and minute, and raises a ring when they first coincide while the alarm is armed. It also drives a buzzer that toggles at 1 Hz, supports snooze with a fixed delay, and stops ringing automatically after a timeout.

## Interface
Parameters:
- SNOOZE_MIN, default 5, snooze delay in minutes; legal range 1..59.
- RING_TIMEOUT_SEC, default 60, seconds of ringing before auto-off; legal range 1..255.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- tick_1hz, input, 1, one-cycle pulse once per second.
- alarm_en, input, 1, alarm armed (level).
- curMinutes, input, 6, current minute 0..59.
- curHours, input, 5, current hour 0..23.
- alarmMinutes, input, 6, alarm minute 0..59.
- alarmHours, input, 5, alarm hour 0..23.
- stop, input, 1, one-cycle pulse that silences the alarm.
- snooze, input, 1, one-cycle pulse that requests a snooze.
- ringing, output, 1, high while in RINGING.
- buzzer, output, 1, 1 Hz toggling drive; low unless ringing.
- snoozing, output, 1, high while in SNOOZE.

## Operation
- States: IDLE, RINGING, SNOOZE.
- match = (curHours==alarmHours) && (curMinutes==alarmMinutes).
- match_q is the registered copy of match, updated every cycle. It resets to 1 so that no trigger occurs in the first cycle after reset.
- IDLE -> RINGING when alarm_en && match && !match_q.
  - Triggering is edge-based: stopping during the matching minute does not retrigger.
  - Arming the alarm while match is already high does not trigger.
  - Moving the alarm time onto the current time while armed does trigger.
- RINGING:
  - The seconds counter sec_cnt is cleared on entry.
  - Each tick_1hz increments sec_cnt and toggles buzzer.
  - buzzer is set to 1 on entry.
- RINGING -> IDLE on stop, on !alarm_en, or on the tick that makes sec_cnt reach RING_TIMEOUT_SEC.
- RINGING -> SNOOZE on snooze.
  - On entry, latch the snooze target as current time + SNOOZE_MIN.
  - Minute arithmetic is 7-bit, wraps mod 60 and carries into the hour.
  - Hour wraps mod 24; for example 23:58 + 5 gives 00:03.
- SNOOZE -> RINGING when the current time equals the snooze target (level compare). This re-entry clears sec_cnt and sets buzzer to 1.
- SNOOZE -> IDLE on stop or !alarm_en.
- snooze received in IDLE or SNOOZE is ignored. stop received in IDLE is ignored.
- Priority within a single cycle: !alarm_en, then stop, then snooze, then timeout, then trigger.
  - snooze on the timeout tick enters SNOOZE.
  - stop and snooze together go to IDLE.
- The original alarm match is not re-evaluated in SNOOZE or RINGING.

## Timing
- Reset state: IDLE; ringing=0, buzzer=0, snoozing=0, sec_cnt=0, match_q=1, snooze target=0.
- Reset asserted mid-ring forces the reset state immediately. No trigger occurs on release, even if match=1.
- Trigger latency: ringing rises one clock edge after the first cycle in which match=1, match_q=0 and alarm_en=1.
- Outputs are registered and decode directly from state; buzzer is a flop.
- stop and snooze take effect at the next edge; outputs change one cycle after the pulse.
- Timeout: ringing falls at the edge that samples the RING_TIMEOUT_SEC-th tick counted since RINGING entry.
- buzzer toggles at the edge sampling each tick while in RINGING. It is forced to 0 in IDLE and SNOOZE.

## Test plan
- Armed alarm at 07:30 with the time stepping from 07:29 to 07:30: ringing=1 on the next cycle, buzzer=1. After 3 ticks buzzer=0, ringing still 1.
- Ringing with no input for 60 ticks: ringing drops at the 60th tick and state returns to IDLE. Holding the time at 07:30 afterwards produces no retrigger.
- Snooze at 23:58 with SNOOZE_MIN=5: snoozing=1, buzzer=0. Time 00:02 gives no ring; 00:03 gives ringing=1 one cycle later.
- Same-cycle events:
  - stop and snooze together while ringing: state goes to IDLE.
  - snooze on the 60th tick: state goes to SNOOZE.
  - Dropping alarm_en during SNOOZE: state goes to IDLE.
- Reset release with time 00:00 equal to alarm 00:00 and alarm armed: no ring. Changing alarmMinutes to 01 and then back to 00 produces a ring.
- Asserting rst asynchronously mid-ring, between clock edges: ringing and buzzer drop to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/alarm_trigger.sv
// Alarm trigger and ringer: rings on the first armed match of clock time and alarm time,
// drives a 1 Hz buzzer, supports snooze with a fixed delay and auto-off after a timeout.
module alarm_trigger #(
   parameter int unsigned SNOOZE_MIN       = 5,
   parameter int unsigned RING_TIMEOUT_SEC = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       alarm_en,
   input  logic [5:0] curMinutes,
   input  logic [4:0] curHours,
   input  logic [5:0] alarmMinutes,
   input  logic [4:0] alarmHours,
   input  logic       stop,
   input  logic       snooze,
   output logic       ringing,
   output logic       buzzer,
   output logic       snoozing
);

   typedef enum logic [1:0] {
      StIdle,
      StRinging,
      StSnooze
   } state_e;

   localparam logic [6:0] SnoozeMin7 = 7'(SNOOZE_MIN);
   localparam logic [7:0] TimeoutCnt = 8'(RING_TIMEOUT_SEC);

   state_e     state_q, state_d;
   logic       match_q;
   logic [7:0] sec_cnt_q, sec_cnt_d;
   logic       buzzer_q, buzzer_d;
   logic [5:0] snz_min_q, snz_min_d;
   logic [4:0] snz_hour_q, snz_hour_d;

   logic       match;
   logic       trigger;
   logic       snz_hit;
   logic [6:0] min_sum;
   logic [5:0] snz_min_calc;
   logic [4:0] snz_hour_calc;
   logic [7:0] sec_next;

   assign match    = (curHours == alarmHours) && (curMinutes == alarmMinutes);
   assign trigger  = alarm_en && match && !match_q;
   assign snz_hit  = (curHours == snz_hour_q) && (curMinutes == snz_min_q);
   assign sec_next = sec_cnt_q + 8'd1;

   // Snooze target: minutes wrap mod 60 carrying into the hour, hour wraps mod 24.
   always_comb begin
      min_sum       = {1'b0, curMinutes} + SnoozeMin7;
      snz_min_calc  = min_sum[5:0];
      snz_hour_calc = curHours;
      if (min_sum >= 7'd60) begin
         snz_min_calc  = 6'(min_sum - 7'd60);
         snz_hour_calc = (curHours == 5'd23) ? 5'd0 : curHours + 5'd1;
      end
   end

   always_comb begin
      state_d    = state_q;
      sec_cnt_d  = sec_cnt_q;
      buzzer_d   = 1'b0;
      snz_min_d  = snz_min_q;
      snz_hour_d = snz_hour_q;

      unique case (state_q)
         StIdle: begin
            if (trigger) begin
               state_d   = StRinging;
               sec_cnt_d = 8'd0;
               buzzer_d  = 1'b1;
            end
         end

         StRinging: begin
            buzzer_d = buzzer_q;
            if (!alarm_en || stop) begin
               state_d  = StIdle;
               buzzer_d = 1'b0;
            end else if (snooze) begin
               state_d    = StSnooze;
               buzzer_d   = 1'b0;
               snz_min_d  = snz_min_calc;
               snz_hour_d = snz_hour_calc;
            end else if (tick_1hz) begin
               sec_cnt_d = sec_next;
               if (sec_next == TimeoutCnt) begin
                  state_d  = StIdle;
                  buzzer_d = 1'b0;
               end else begin
                  buzzer_d = ~buzzer_q;
               end
            end
         end

         StSnooze: begin
            if (!alarm_en || stop) begin
               state_d = StIdle;
            end else if (snz_hit) begin
               state_d   = StRinging;
               sec_cnt_d = 8'd0;
               buzzer_d  = 1'b1;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // match_q resets high so a match present at reset release is not seen as an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         match_q    <= 1'b1;
         sec_cnt_q  <= 8'd0;
         buzzer_q   <= 1'b0;
         snz_min_q  <= 6'd0;
         snz_hour_q <= 5'd0;
      end else begin
         state_q    <= state_d;
         match_q    <= match;
         sec_cnt_q  <= sec_cnt_d;
         buzzer_q   <= buzzer_d;
         snz_min_q  <= snz_min_d;
         snz_hour_q <= snz_hour_d;
      end
   end

   assign ringing  = (state_q == StRinging);
   assign snoozing = (state_q == StSnooze);
   assign buzzer   = buzzer_q;

endmodule
